tof_i2c_arbiter: RTL and testbench
==================================

// Module: tof_i2c_arbiter
// PURPOSE
// Shares the single I2C transaction engine (register_address/is_read/nb_of_bytes/start/ready/error_in)
// between NUM_REQ requesters: per-sensor ToF sequencers plus the configuration loader.
// Round-robin grant, one transaction at a time, with completion/error reporting and a watchdog.
// owner_index steers the engine's read-data path and the sensor_index tag of returned distance data.
// PARAMETERS
// NUM_REQ         4        number of requesters (>=2)
// ADDR_W          16       register address width
// LEN_W           10       byte-count width
// TIMEOUT_CYCLES  1000000  max cycles in WAIT_ACK+WAIT_DONE before forced abort (>=2)
// IDX_W           $clog2(NUM_REQ)  owner index width (derived)
// PORTS
// clk            in   1               system clock, all logic rising-edge
// reset          in   1               asynchronous, active-high
// req            in   NUM_REQ         level request, held until own done pulse
// req_addr       in   NUM_REQ*ADDR_W  requester i at [ADDR_W*i +: ADDR_W]
// req_is_read    in   NUM_REQ         1=read, 0=write
// req_nb_bytes   in   NUM_REQ*LEN_W   requester i at [LEN_W*i +: LEN_W]
// grant          out  NUM_REQ         one-hot owner, high from latch until done cycle inclusive
// done           out  NUM_REQ         1-cycle completion pulse to owner
// err            out  NUM_REQ         1-cycle, coincident with done; engine error, timeout or zero length
// register_address out ADDR_W         latched address of owner
// is_read        out  1               latched direction of owner
// nb_of_bytes    out  LEN_W           latched length of owner
// start          out  1               1-cycle launch pulse to engine
// ready          in   1               engine idle (high) / busy (low)
// error_in       in   1               engine error flag
// owner_index    out  IDX_W           binary index of current/last owner
// busy           out  1               high in every state except IDLE
// BEHAVIOUR
// - Reset: state IDLE, grant/done/err/start/busy=0, register_address/nb_of_bytes/is_read/owner_index=0,
//   rr pointer so requester 0 has top priority, timeout counter 0. Reset mid-transaction aborts silently (no done).
// - All outputs registered. FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> RELEASE -> IDLE.
// - IDLE: if any req, pick first set bit searching from last_owner+1 upward with wrap (round robin);
//   latch addr/is_read/nb_bytes/owner_index, set grant -> ISSUE. Req seen at cycle N => grant at N+1.
// - Zero length: if latched nb_bytes==0, ISSUE goes to RELEASE with err flag set, start never issued.
// - ISSUE: wait for ready=1; then start=1 for exactly the next cycle, -> WAIT_ACK (earliest start N+2).
// - WAIT_ACK: wait for ready=0 (engine accepted). WAIT_DONE: wait for ready=1 -> RELEASE.
// - error_in sampled every cycle in WAIT_ACK/WAIT_DONE into sticky err flag (cleared on latch).
// - Timeout: counter runs in WAIT_ACK+WAIT_DONE; reaching TIMEOUT_CYCLES -> RELEASE with err flag set.
// - RELEASE (1 cycle): done[owner]=1, err[owner]=err flag, grant cleared at end; last_owner=owner -> IDLE.
// - Requester dropping req mid-transaction: transaction still completes, done still pulses.
// - Requester keeping req after done: eligible again only after other pending requesters (fairness).
// - Outputs register_address/is_read/nb_of_bytes stable from grant until next latch; never change mid-transfer.
// - Min IDLE-to-IDLE turnaround: 1 cycle in IDLE between transactions.
// TESTING
// 1. req[0], addr 16'h0010, write, 2 bytes; engine drops ready 1 cycle after start for 3 cycles -> one start
//    pulse at N+2, outputs 16'h0010/0/2, done[0]=1 err[0]=0, grant[0] low after done.
// 2. req[3:0]=4'b1111 held, each reissued on done -> grant order 0,1,2,3,0; no double grant, start count=5.
// 3. req[2] read 512 bytes, error_in pulsed 1 cycle in WAIT_DONE -> done[2]=1 & err[2]=1, others 0.
// 4. TIMEOUT_CYCLES=100, engine keeps ready=1 after start -> done+err exactly 100 cycles after WAIT_ACK entry, busy=0 next.
// 5. req[1] with nb_bytes=0 -> no start, done[1]=1 & err[1]=1 two cycles after grant.
// 6. reset pulsed in WAIT_DONE of req[2] with req[1],req[3] pending -> all outputs 0 same cycle, no done;
//    after release first grant goes to req[1].

Source files
------------

// File: rtl/tof_i2c_arbiter_if.sv
// ---------------------------------------------------------------------------
// tof_i2c_arbiter_if
// Bundle between the NUM_REQ requesters, the I2C transaction engine and the
// arbiter that shares the engine between them.
//   req / req_addr / req_is_read / req_nb_bytes : per-requester transaction
//       request; requester i occupies slice i of each packed vector
//   grant / done / err                          : per-requester one-hot status
//   register_address / is_read / nb_of_bytes    : latched transaction of owner
//   start / ready / error_in                    : engine handshake
//   owner_index / busy                          : current owner and activity
// modport master : arbiter side (drives the engine and the status outputs)
// modport slave  : environment side (requesters + engine)
// ---------------------------------------------------------------------------
interface tof_i2c_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 10,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_is_read;
    logic [NUM_REQ*LEN_W-1:0]  req_nb_bytes;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [ADDR_W-1:0]         register_address;
    logic                      is_read;
    logic [LEN_W-1:0]          nb_of_bytes;
    logic                      start;
    logic                      ready;
    logic                      error_in;
    logic [IDX_W-1:0]          owner_index;
    logic                      busy;

    modport master (
        input  req, req_addr, req_is_read, req_nb_bytes, ready, error_in,
        output grant, done, err, register_address, is_read, nb_of_bytes,
               start, owner_index, busy
    );

    modport slave (
        output req, req_addr, req_is_read, req_nb_bytes, ready, error_in,
        input  grant, done, err, register_address, is_read, nb_of_bytes,
               start, owner_index, busy
    );
endinterface

// File: rtl/tof_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tof_i2c_arbiter
// Round-robin sharing of a single I2C transaction engine between NUM_REQ
// requesters (per-sensor ToF sequencers and the configuration loader). One
// transaction at a time; completion/error pulse back to the owner and a
// watchdog that aborts a transaction the engine never finishes.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; aborts any transaction silently
//   bus   : tof_i2c_arbiter_if.master (requests, status, engine handshake)
// All outputs are registered.
// ---------------------------------------------------------------------------
module tof_i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 16,
    parameter int LEN_W          = 10,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    tof_i2c_arbiter_if.master  bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RELEASE} state_e;

    // The watchdog window spans WAIT_ACK entry up to the done pulse: the
    // WAIT states last TIMEOUT_CYCLES-1 cycles, RELEASE adds the last one.
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rd_q, rd_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 errf_q, errf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;

    // Round-robin pick: scan from the farthest slot towards last_q+1 so the
    // nearest requester after the previous owner is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        addr_d  = addr_q;
        rd_d    = rd_q;
        len_d   = len_q;
        owner_d = owner_q;
        last_d  = last_q;
        start_d = 1'b0;
        errf_d  = errf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // grant of the previous owner stays visible through its done cycle
                grant_d = '0;
                if (pick_vld) begin
                    grant_d[pick_idx] = 1'b1;
                    addr_d  = bus.req_addr[ADDR_W*pick_idx +: ADDR_W];
                    rd_d    = bus.req_is_read[pick_idx];
                    len_d   = bus.req_nb_bytes[LEN_W*pick_idx +: LEN_W];
                    owner_d = pick_idx;
                    errf_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (len_q == '0) begin
                    // nothing to transfer: report an error without touching the engine
                    errf_d  = 1'b1;
                    state_d = RELEASE;
                end else if (bus.ready) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK, WAIT_DONE: begin
                errf_d = errf_q | bus.error_in;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == TMO_LAST) begin
                    errf_d  = 1'b1;
                    state_d = RELEASE;
                end else if (state_q == WAIT_ACK && !bus.ready) begin
                    state_d = WAIT_DONE;
                end else if (state_q == WAIT_DONE && bus.ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                done_d  = grant_q;
                err_d   = errf_q ? grant_q : '0;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            len_q   <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            errf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            errf_q  <= errf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant            = grant_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.register_address = addr_q;
    assign bus.is_read          = rd_q;
    assign bus.nb_of_bytes      = len_q;
    assign bus.start            = start_q;
    assign bus.owner_index      = owner_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tof_i2c_arbiter
// Directed bench for the I2C engine arbiter: a small engine model answers
// start pulses, a scoreboard queue holds the expected done/err/owner/data of
// each transaction and is checked whenever a done pulse appears.
// ---------------------------------------------------------------------------
module tb_tof_i2c_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 10;
    localparam int TMO     = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tof_i2c_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    tof_i2c_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic [NUM_REQ-1:0] err;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic               rd;
        logic [1:0]         owner;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int starts = 0;
    int onehot_bad = 0;

    // engine model controls
    int eng_len = 3;
    int elen;
    bit eng_err = 1'b0;
    bit eng_hang = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic rd,
                           input logic [LEN_W-1:0] n);
        bus.req_addr[ADDR_W*i +: ADDR_W]  = a;
        bus.req_is_read[i]                = rd;
        bus.req_nb_bytes[LEN_W*i +: LEN_W] = n;
    endtask

    task automatic push(input int i, input logic er, input logic [ADDR_W-1:0] a,
                        input logic rd, input logic [LEN_W-1:0] n);
        exp_t x;
        x.done  = 4'b0001 << i;
        x.err   = er ? (4'b0001 << i) : 4'b0000;
        x.addr  = a;
        x.len   = n;
        x.rd    = rd;
        x.owner = 2'(i);
        sbq.push_back(x);
    endtask

    // Advance at least one cycle, stop at a done pulse or after maxc cycles.
    task automatic wait_done(input int maxc, output int at);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(|bus.done) && n < maxc);
        if (!(|bus.done)) chk("done_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic wait_start(input int maxc, output int at);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.start && n < maxc);
        if (!bus.start) chk("start_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    // Engine: after a start pulse, drop ready one cycle later for elen cycles;
    // optional error_in pulse on the second busy cycle; hang keeps ready high.
    initial begin
        bus.ready    = 1'b1;
        bus.error_in = 1'b0;
        forever begin
            tick();
            if (bus.start && !eng_hang) begin
                elen = eng_len;
                tick();
                for (int k = 0; k < elen; k++) begin
                    bus.ready    = 1'b0;
                    bus.error_in = eng_err && (k == 1);
                    tick();
                end
                bus.ready    = 1'b1;
                bus.error_in = 1'b0;
            end
        end
    end

    // Monitor + scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.start) starts++;
            if (!$onehot0(bus.grant)) onehot_bad++;
            if (|bus.done) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_done",  32'(bus.done), 32'(e.done));
                    chk("sb_err",   32'(bus.err), 32'(e.err));
                    chk("sb_owner", 32'(bus.owner_index), 32'(e.owner));
                    chk("sb_addr",  32'(bus.register_address), 32'(e.addr));
                    chk("sb_len",   32'(bus.nb_of_bytes), 32'(e.len));
                    chk("sb_rd",    32'(bus.is_read), 32'(e.rd));
                    chk("sb_grant", 32'(bus.grant), 32'(e.done));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, ts, gc, s0;
        reset            = 1'b1;
        bus.req          = '0;
        bus.req_addr     = '0;
        bus.req_is_read  = '0;
        bus.req_nb_bytes = '0;
        tick();
        tick();
        // reset state
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_addr",  32'(bus.register_address), 32'd0);
        chk("rst_len",   32'(bus.nb_of_bytes), 32'd0);
        chk("rst_rd",    32'(bus.is_read), 32'd0);
        chk("rst_owner", 32'(bus.owner_index), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single write, 2 bytes
        set_req(0, 16'h0010, 1'b0, 10'd2);
        push(0, 1'b0, 16'h0010, 1'b0, 10'd2);
        bus.req[0] = 1'b1;
        t0 = cyc;
        tick();
        chk("t1_grant", 32'(bus.grant), 32'b0001);
        chk("t1_busy",  32'(bus.busy), 32'd1);
        chk("t1_addr",  32'(bus.register_address), 32'h0010);
        chk("t1_start_early", 32'(bus.start), 32'd0);
        tick();
        chk("t1_start", 32'(bus.start), 32'd1);
        tick();
        chk("t1_start_1cyc", 32'(bus.start), 32'd0);
        wait_done(50, at);
        chk("t1_done_lat", 32'(at - t0), 32'd8);
        bus.req[0] = 1'b0;
        tick();
        chk("t1_grant_off", 32'(bus.grant), 32'd0);

        // 2: all four held, round robin 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        s0 = starts;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 16'h0100 + 16'(i), 1'(i), 10'(i + 1));
        for (int n = 0; n < 5; n++)
            push(n % NUM_REQ, 1'b0, 16'h0100 + 16'(n % NUM_REQ), 1'(n % NUM_REQ), 10'((n % NUM_REQ) + 1));
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(60, at);
            if (n == 4) bus.req = '0;
        end
        tick();
        chk("t2_starts", 32'(starts - s0), 32'd5);

        // 3: read 512 bytes, engine error during WAIT_DONE
        set_req(2, 16'h0A5A, 1'b1, 10'd512);
        push(2, 1'b1, 16'h0A5A, 1'b1, 10'd512);
        eng_err = 1'b1;
        bus.req[2] = 1'b1;
        wait_done(60, at);
        chk("t3_done", 32'(bus.done), 32'b0100);
        chk("t3_err",  32'(bus.err), 32'b0100);
        bus.req[2] = 1'b0;
        eng_err = 1'b0;
        tick();

        // 4: engine never responds -> watchdog abort
        eng_hang = 1'b1;
        set_req(3, 16'h0BEE, 1'b0, 10'd4);
        push(3, 1'b1, 16'h0BEE, 1'b0, 10'd4);
        bus.req[3] = 1'b1;
        wait_start(10, ts);
        wait_done(200, at);
        chk("t4_tmo_lat", 32'(at - ts), 32'(TMO));
        bus.req[3] = 1'b0;
        tick();
        chk("t4_busy_off", 32'(bus.busy), 32'd0);
        eng_hang = 1'b0;
        tick();

        // 5: zero length
        set_req(1, 16'h0020, 1'b0, 10'd0);
        push(1, 1'b1, 16'h0020, 1'b0, 10'd0);
        s0 = starts;
        bus.req[1] = 1'b1;
        tick();
        gc = cyc;
        chk("t5_grant", 32'(bus.grant), 32'b0010);
        wait_done(20, at);
        chk("t5_done_lat", 32'(at - gc), 32'd2);
        bus.req[1] = 1'b0;
        tick();
        chk("t5_no_start", 32'(starts - s0), 32'd0);

        // 6: reset during WAIT_DONE of req[2] with req[1], req[3] pending
        eng_len = 20;
        set_req(1, 16'h0031, 1'b1, 10'd3);
        set_req(2, 16'h0032, 1'b0, 10'd5);
        set_req(3, 16'h0033, 1'b0, 10'd6);
        bus.req = 4'b1110;
        wait_start(10, ts);
        tick();
        tick();
        tick();
        chk("t6_pre_grant", 32'(bus.grant), 32'b0100);
        reset = 1'b1;
        bus.req[2] = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(bus.grant), 32'd0);
        chk("t6_rst_busy",  32'(bus.busy), 32'd0);
        chk("t6_rst_done",  32'(bus.done), 32'd0);
        chk("t6_rst_addr",  32'(bus.register_address), 32'd0);
        chk("t6_rst_owner", 32'(bus.owner_index), 32'd0);
        push(1, 1'b0, 16'h0031, 1'b1, 10'd3);
        push(3, 1'b0, 16'h0033, 1'b0, 10'd6);
        tick();
        reset = 1'b0;
        eng_len = 3;
        tick();
        chk("t6_first_grant", 32'(bus.grant), 32'b0010);
        wait_done(100, at);
        bus.req[1] = 1'b0;
        wait_done(100, at);
        bus.req[3] = 1'b0;
        tick();
        tick();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("grant_onehot", 32'(onehot_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
